// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB completer memory.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        ACCESS
    } state_t;

    localparam int unsigned WCW = 4;

    localparam logic [63:0] ERR_RDATA = '0;

endpackage

// File: rtl/apb_slave_ram.sv
// Word array behind the APB completer: synchronous write, asynchronous read, cleared on reset.
module apb_slave_ram
    import apb_slave_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 192
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we && (32'(waddr) < DEPTH)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Out-of-range reads never index past the array.
    assign rdata = (32'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer memory: latches the setup phase, inserts WAIT_CYCLES wait states,
// and answers with registered pready/prdata/pslverr; out-of-range words raise pslverr.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 8,
    parameter int unsigned DEPTH       = 192,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [DW-1:0] pwdata,
    output logic          pready,
    output logic [DW-1:0] prdata,
    output logic          pslverr
);

    localparam logic [WCW-1:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? '0 : WCW'(WAIT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           wr_q, wr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           pready_q, pready_d;
    logic           pslverr_q, pslverr_d;
    logic [DW-1:0]  prdata_q, prdata_d;

    logic           start;
    logic           ram_we;
    logic [DW-1:0]  ram_rdata;

    apb_slave_ram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (pclk),
        .rst   (preset),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_d),
        .rdata (ram_rdata)
    );

    // Next state; outputs are precomputed so they are valid in the cycle the state is entered.
    // SETUP is the first access-phase cycle of a transfer that has wait states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        start     = 1'b0;
        ram_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                start = psel && !penable;
            end
            SETUP, WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable) begin
                    if (cnt_q == '0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d   = cnt_q - WCW'(1);
                        state_d = WAIT;
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (psel && penable) begin
                    ram_we = wr_q && !err_q;
                end else if (psel) begin
                    start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            addr_d  = paddr;
            wr_d    = pwrite;
            wdata_d = pwdata;
            err_d   = 32'(paddr) >= DEPTH;
            cnt_d   = WAIT_LOAD;
            state_d = (WAIT_CYCLES == 0) ? ACCESS : SETUP;
        end

        if (state_d == ACCESS) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            if (!wr_d) begin
                prdata_d = err_d ? DW'(ERR_RDATA) : ram_rdata;
            end
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized bench for apb_slave_mem: three instances (1, 0 and 2 wait states; the last with a full
// 256-word map) checked every cycle against a transaction-level model of timing and memory contents.
module tb_apb_slave_mem;

    localparam int NDUT = 3;
    localparam int WCS    [NDUT] = '{1, 0, 2};
    localparam int DEPTHS [NDUT] = '{192, 192, 256};

    logic       pclk;
    logic       preset;
    logic       psel    [NDUT];
    logic       penable [NDUT];
    logic       pwrite  [NDUT];
    logic [7:0] paddr   [NDUT];
    logic [7:0] pwdata  [NDUT];
    logic       pready  [NDUT];
    logic       pslverr [NDUT];
    logic [7:0] prdata  [NDUT];

    logic       exp_pready  [NDUT];
    logic       exp_pslverr [NDUT];
    logic [7:0] exp_prdata  [NDUT];
    logic [7:0] mem [NDUT][256];

    bit    pin_en;
    int    pin_dut, pin_data, pin_err;
    string pin_name;

    int vectors;
    int miscompares;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_mem #(
            .AW          (8),
            .DW          (8),
            .DEPTH       (DEPTHS[g]),
            .WAIT_CYCLES (WCS[g])
        ) u_dut (
            .pclk    (pclk),
            .preset  (preset),
            .psel    (psel[g]),
            .penable (penable[g]),
            .pwrite  (pwrite[g]),
            .paddr   (paddr[g]),
            .pwdata  (pwdata[g]),
            .pready  (pready[g]),
            .prdata  (prdata[g]),
            .pslverr (pslverr[g])
        );
    end

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Per-cycle comparison against the model, plus literal pins on selected completions.
    always @(negedge pclk) begin
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (pready[d] !== exp_pready[d]) begin
                miscompares++;
                $display("FAIL pready dut%0d t=%0t: got %b want %b", d, $time, pready[d], exp_pready[d]);
            end
            vectors++;
            if (pslverr[d] !== exp_pslverr[d]) begin
                miscompares++;
                $display("FAIL pslverr dut%0d t=%0t: got %b want %b", d, $time, pslverr[d], exp_pslverr[d]);
            end
            vectors++;
            if (prdata[d] !== exp_prdata[d]) begin
                miscompares++;
                $display("FAIL prdata dut%0d t=%0t: got %h want %h", d, $time, prdata[d], exp_prdata[d]);
            end
        end
        if (pin_en) begin
            vectors++;
            if (pready[pin_dut] !== 1'b1
                || (pin_data >= 0 && prdata[pin_dut] !== 8'(pin_data))
                || (pin_err >= 0 && pslverr[pin_dut] !== 1'(pin_err))) begin
                miscompares++;
                $display("FAIL %s dut%0d: got pready=%b prdata=%h pslverr=%b, want pready=1 prdata=%0d pslverr=%0d",
                         pin_name, pin_dut, pready[pin_dut], prdata[pin_dut], pslverr[pin_dut], pin_data, pin_err);
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int d);
        psel[d]        = 1'b0;
        penable[d]     = 1'($urandom);
        paddr[d]       = 8'($urandom);
        exp_pready[d]  = 1'b0;
        exp_pslverr[d] = 1'b0;
        tick();
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            psel[d]        = 1'b0;
            penable[d]     = 1'b0;
            exp_pready[d]  = 1'b0;
            exp_pslverr[d] = 1'b0;
            exp_prdata[d]  = 8'h00;
            for (int a = 0; a < 256; a++) mem[d][a] = 8'h00;
        end
    endtask

    // One APB transfer of 2 + wait-state cycles. abort_k drops psel in that access cycle;
    // scr = -2 scrambles address/data/direction during access, scr >= 0 moves paddr there.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                        input int abort_k, input int scr, input int pd, input int pe,
                        input bit b2b, input string nm);
        int n;
        bit err;
        bit aborted;
        n       = 2 + WCS[d];
        err     = int'(addr) >= DEPTHS[d];
        aborted = 1'b0;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        exp_pready[d]  = 1'b0;
        exp_pslverr[d] = 1'b0;
        tick();
        for (int k = 1; k < n; k++) begin
            penable[d] = 1'b1;
            if (k == abort_k) begin
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
                aborted    = 1'b1;
            end
            if (scr == -2) begin
                paddr[d]  = 8'($urandom);
                pwdata[d] = 8'($urandom);
                pwrite[d] = 1'($urandom);
            end else if (scr >= 0) begin
                paddr[d] = 8'(scr);
            end
            if (k == n - 1) begin
                exp_pready[d]  = 1'b1;
                exp_pslverr[d] = err;
                if (!wr) exp_prdata[d] = err ? 8'h00 : mem[d][addr];
                pin_dut  = d;
                pin_data = pd;
                pin_err  = pe;
                pin_name = nm;
                pin_en   = (pd >= 0 || pe >= 0) && !aborted;
            end
            tick();
            pin_en = 1'b0;
            if (aborted) break;
        end
        if (!aborted && wr && !err) mem[d][addr] = data;
        if (!b2b || aborted) idle(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        pin_en      = 1'b0;
        pin_dut     = 0;
        pin_data    = -1;
        pin_err     = -1;
        pin_name    = "";
        preset      = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            pwrite[d] = 1'b0;
            paddr[d]  = 8'h00;
            pwdata[d] = 8'h00;
        end
        clear_model();
        tick();
        tick();
        preset = 1'b0;
        tick();

        // One wait state: write then read back.
        xfer(0, 1'b1, 8'h03, 8'hA5, -1, -1, -1, 0, 1'b1, "ws1_write");
        xfer(0, 1'b0, 8'h03, 8'h00, -1, -1, 8'hA5, 0, 1'b0, "ws1_read");

        // Zero wait states: back-to-back writes then reads.
        xfer(1, 1'b1, 8'h00, 8'h11, -1, -1, -1, -1, 1'b1, "ws0_w0");
        xfer(1, 1'b1, 8'hBF, 8'h22, -1, -1, -1, -1, 1'b1, "ws0_w1");
        xfer(1, 1'b0, 8'h00, 8'h00, -1, -1, 8'h11, 0, 1'b1, "ws0_r0");
        xfer(1, 1'b0, 8'hBF, 8'h00, -1, -1, 8'h22, 0, 1'b0, "ws0_r1");

        // Out of range at DEPTH; DEPTH-1 remains a normal word.
        xfer(0, 1'b1, 8'hBF, 8'h66, -1, -1, -1, 0, 1'b1, "last_word_write");
        xfer(0, 1'b1, 8'hC0, 8'h5A, -1, -1, -1, 1, 1'b1, "oor_write");
        xfer(0, 1'b0, 8'hC0, 8'h00, -1, -1, 8'h00, 1, 1'b1, "oor_read");
        xfer(0, 1'b0, 8'hBF, 8'h00, -1, -1, 8'h66, 0, 1'b0, "last_word_read");

        // Abort during the wait state leaves the old contents.
        xfer(0, 1'b1, 8'h05, 8'h33, -1, -1, -1, 0, 1'b0, "abort_pre");
        xfer(0, 1'b1, 8'h05, 8'h77, 1, -1, -1, -1, 1'b0, "abort_write");
        xfer(0, 1'b0, 8'h05, 8'h00, -1, -1, 8'h33, 0, 1'b0, "abort_read");

        // Address moves during access; the latched one wins.
        xfer(0, 1'b1, 8'h04, 8'h44, -1, -1, -1, 0, 1'b1, "stab_w4");
        xfer(0, 1'b1, 8'h06, 8'h66, -1, -1, -1, 0, 1'b1, "stab_w6");
        xfer(0, 1'b0, 8'h04, 8'h00, -1, 8'h06, 8'h44, 0, 1'b0, "stab_read");

        // Full 256-word map never flags an error.
        xfer(2, 1'b1, 8'hFF, 8'h9E, -1, -1, -1, 0, 1'b1, "full_map_write");
        xfer(2, 1'b0, 8'hFF, 8'h00, -1, -1, 8'h9E, 0, 1'b0, "full_map_read");

        // Reset during the wait state of a write.
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h10;
        pwdata[0]  = 8'hEE;
        tick();
        penable[0] = 1'b1;
        #1;
        preset = 1'b1;
        clear_model();
        tick();
        tick();
        preset = 1'b0;
        tick();
        xfer(0, 1'b0, 8'h10, 8'h00, -1, -1, 8'h00, 0, 1'b0, "post_reset_read");

        // Randomized bursts on a random instance.
        for (int b = 0; b < 80; b++) begin
            int d;
            int len;
            d   = int'($urandom_range(0, NDUT - 1));
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                logic [7:0] a;
                int         ab;
                int         sc;
                case ($urandom_range(0, 5))
                    0:       a = 8'(DEPTHS[d] - 1);
                    1:       a = 8'(DEPTHS[d]);
                    2, 3:    a = 8'($urandom_range(0, 7));
                    default: a = 8'($urandom);
                endcase
                ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 1 + WCS[d])) : -1;
                sc = ($urandom_range(0, 3) == 0) ? -2 : -1;
                xfer(d, 1'($urandom), a, 8'($urandom), ab, sc, -1, -1, j != len - 1, "rand");
            end
        end

        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
